// File: rtl/mem_write_buffer.sv
// In-order store buffer in front of a single-write-port array, with optional
// read forwarding of pending writes (enabled by MEM_WRITE_BUFFER_BYPASS_EN).
module mem_write_buffer #(
    parameter int ADDR_SIZE = 4,
    parameter int BYTE_SIZE = 8,
    parameter int DEPTH     = 4,
    parameter int LOG_DEPTH = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ADDR_SIZE-1:0] in_addr,
    input  logic [BYTE_SIZE-1:0] in_data,
    input  logic                 hold,
    output logic                 mem_wen,
    output logic [ADDR_SIZE-1:0] mem_waddr,
    output logic [BYTE_SIZE-1:0] mem_wdata,
    input  logic [ADDR_SIZE-1:0] raddr1,
    input  logic [ADDR_SIZE-1:0] raddr2,
    input  logic [BYTE_SIZE-1:0] mem_rdata1,
    input  logic [BYTE_SIZE-1:0] mem_rdata2,
    output logic [BYTE_SIZE-1:0] rdata1,
    output logic [BYTE_SIZE-1:0] rdata2,
    output logic [LOG_DEPTH:0]   count,
    output logic                 empty
);

    localparam logic [LOG_DEPTH:0] FULL_COUNT = (LOG_DEPTH+1)'(DEPTH);

    logic [ADDR_SIZE-1:0] addr_mem [DEPTH];
    logic [BYTE_SIZE-1:0] data_mem [DEPTH];

    logic [LOG_DEPTH-1:0] head_reg, head_next;
    logic [LOG_DEPTH-1:0] tail_reg, tail_next;
    logic [LOG_DEPTH:0]   count_reg, count_next;
    logic                 push;
    logic                 pop;

    assign in_ready  = !reset && (count_reg != FULL_COUNT);
    assign mem_wen   = !reset && (count_reg != '0) && !hold;
    assign push      = in_valid && in_ready;
    assign pop       = mem_wen;
    assign mem_waddr = addr_mem[head_reg];
    assign mem_wdata = data_mem[head_reg];
    assign count     = count_reg;
    assign empty     = (count_reg == '0);

    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (push) begin
            tail_next = tail_reg + 1'b1;
        end
        if (pop) begin
            head_next = head_reg + 1'b1;
        end
        if (push && !pop) begin
            count_next = count_reg + 1'b1;
        end else if (pop && !push) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    // Payload storage carries no reset; occupancy is tracked by count_reg alone.
    always_ff @(posedge clock) begin
        if (push) begin
            addr_mem[tail_reg] <= in_addr;
            data_mem[tail_reg] <= in_data;
        end
    end

`ifdef MEM_WRITE_BUFFER_BYPASS_EN
    logic [DEPTH-1:0]     match1;
    logic [DEPTH-1:0]     match2;
    logic [LOG_DEPTH-1:0] slot [DEPTH];
    logic [BYTE_SIZE-1:0] fwd_data [DEPTH];

    // Index by age (0 = head, oldest) so the highest matching index is the youngest.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
        logic occupied;
        assign slot[gi]     = head_reg + LOG_DEPTH'(gi);
        assign occupied     = (LOG_DEPTH+1)'(gi) < count_reg;
        assign match1[gi]   = occupied && (addr_mem[slot[gi]] == raddr1);
        assign match2[gi]   = occupied && (addr_mem[slot[gi]] == raddr2);
        assign fwd_data[gi] = data_mem[slot[gi]];
    end

    always_comb begin
        rdata1 = mem_rdata1;
        rdata2 = mem_rdata2;
        for (int i = 0; i < DEPTH; i++) begin
            if (match1[i]) begin
                rdata1 = fwd_data[i];
            end
            if (match2[i]) begin
                rdata2 = fwd_data[i];
            end
        end
    end
`else
    assign rdata1 = mem_rdata1;
    assign rdata2 = mem_rdata2;
`endif

endmodule

// File: tb/tb_mem_write_buffer.sv
// Directed bench for mem_write_buffer: table of per-cycle vectors plus
// hand-written reset sequences, against a behavioural model of the array.
module tb_mem_write_buffer;

    logic       clock;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_addr;
    logic [7:0] in_data;
    logic       hold;
    logic       mem_wen;
    logic [3:0] mem_waddr;
    logic [7:0] mem_wdata;
    logic [3:0] raddr1;
    logic [3:0] raddr2;
    logic [7:0] mem_rdata1;
    logic [7:0] mem_rdata2;
    logic [7:0] rdata1;
    logic [7:0] rdata2;
    logic [2:0] count;
    logic       empty;

    int checks = 0;
    int errors = 0;

    mem_write_buffer #(
        .ADDR_SIZE(4), .BYTE_SIZE(8), .DEPTH(4), .LOG_DEPTH(2)
    ) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data), .hold(hold),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .raddr1(raddr1), .raddr2(raddr2),
        .mem_rdata1(mem_rdata1), .mem_rdata2(mem_rdata2),
        .rdata1(rdata1), .rdata2(rdata2),
        .count(count), .empty(empty)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural register array: async read, written at the edge when mem_wen.
    logic [7:0] array_q [16];
    initial begin
        for (int i = 0; i < 16; i++) array_q[i] = 8'h00;
        array_q[6] = 8'h66;
    end
    always @(posedge clock) begin
        if (mem_wen) array_q[mem_waddr] <= mem_wdata;
    end
    assign mem_rdata1 = array_q[raddr1];
    assign mem_rdata2 = array_q[raddr2];

    typedef struct {
        logic       v;
        logic [3:0] a;
        logic [7:0] d;
        logic       h;
        logic [3:0] r1;
        logic [3:0] r2;
        logic       e_rdy;
        logic       e_wen;
        logic [3:0] e_waddr;
        logic [7:0] e_wdata;
        logic [2:0] e_cnt;
        logic [7:0] e_r1f;
        logic [7:0] e_r1r;
        logic [7:0] e_r2f;
        logic [7:0] e_r2r;
    } vec_t;

    function automatic vec_t mk(input int v, input int a, input int d, input int h,
                                input int r1, input int r2, input int rdy, input int wen,
                                input int wa, input int wd, input int cnt,
                                input int r1f, input int r1r, input int r2f, input int r2r);
        vec_t m;
        m.v = v[0];       m.a = a[3:0];      m.d = d[7:0];      m.h = h[0];
        m.r1 = r1[3:0];   m.r2 = r2[3:0];    m.e_rdy = rdy[0];  m.e_wen = wen[0];
        m.e_waddr = wa[3:0]; m.e_wdata = wd[7:0]; m.e_cnt = cnt[2:0];
        m.e_r1f = r1f[7:0]; m.e_r1r = r1r[7:0]; m.e_r2f = r2f[7:0]; m.e_r2r = r2r[7:0];
        return m;
    endfunction

    task automatic check(input string name, input int row, input logic [7:0] act,
                         input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    vec_t vecs [20];

    initial begin
        // v  a  d    h  r1 r2 rdy wen wa wd   cnt r1f   r1r   r2f   r2r
        vecs[0]  = mk(1, 3, 'hA5, 0, 3, 0, 1, 0, 0, 0,    0, 'h00, 'h00, 'h00, 'h00);
        vecs[1]  = mk(0, 0, 0,    0, 3, 3, 1, 1, 3, 'hA5, 1, 'hA5, 'h00, 'hA5, 'h00);
        vecs[2]  = mk(0, 0, 0,    0, 3, 4, 1, 0, 0, 0,    0, 'hA5, 'hA5, 'h00, 'h00);
        vecs[3]  = mk(1, 0, 'h10, 1, 0, 1, 1, 0, 0, 0,    0, 'h00, 'h00, 'h00, 'h00);
        vecs[4]  = mk(1, 1, 'h11, 1, 0, 1, 1, 0, 0, 0,    1, 'h10, 'h00, 'h00, 'h00);
        vecs[5]  = mk(1, 2, 'h12, 1, 1, 2, 1, 0, 0, 0,    2, 'h11, 'h00, 'h00, 'h00);
        vecs[6]  = mk(1, 3, 'h13, 1, 3, 2, 1, 0, 0, 0,    3, 'hA5, 'hA5, 'h12, 'h00);
        vecs[7]  = mk(1, 4, 'h14, 1, 3, 0, 0, 0, 0, 0,    4, 'h13, 'hA5, 'h10, 'h00);
        vecs[8]  = mk(1, 4, 'h14, 0, 0, 4, 0, 1, 0, 'h10, 4, 'h10, 'h00, 'h00, 'h00);
        vecs[9]  = mk(1, 4, 'h14, 0, 0, 1, 1, 1, 1, 'h11, 3, 'h10, 'h10, 'h11, 'h00);
        vecs[10] = mk(0, 0, 0,    0, 4, 2, 1, 1, 2, 'h12, 3, 'h14, 'h00, 'h12, 'h00);
        vecs[11] = mk(1, 7, 'h77, 0, 3, 7, 1, 1, 3, 'h13, 2, 'h13, 'hA5, 'h00, 'h00);
        vecs[12] = mk(0, 0, 0,    0, 3, 7, 1, 1, 4, 'h14, 2, 'h13, 'h13, 'h77, 'h00);
        vecs[13] = mk(0, 0, 0,    1, 4, 7, 1, 0, 0, 0,    1, 'h14, 'h14, 'h77, 'h00);
        vecs[14] = mk(0, 0, 0,    0, 7, 1, 1, 1, 7, 'h77, 1, 'h77, 'h00, 'h11, 'h11);
        vecs[15] = mk(0, 0, 0,    0, 7, 2, 1, 0, 0, 0,    0, 'h77, 'h77, 'h12, 'h12);
        vecs[16] = mk(1, 5, 'h11, 1, 5, 6, 1, 0, 0, 0,    0, 'h00, 'h00, 'h66, 'h66);
        vecs[17] = mk(1, 5, 'h22, 1, 5, 6, 1, 0, 0, 0,    1, 'h11, 'h00, 'h66, 'h66);
        vecs[18] = mk(0, 0, 0,    1, 5, 6, 1, 0, 0, 0,    2, 'h22, 'h00, 'h66, 'h66);
        vecs[19] = mk(1, 8, 'h88, 1, 8, 5, 1, 0, 0, 0,    2, 'h00, 'h00, 'h22, 'h00);

        // Reset held two cycles with a request pending.
        reset = 1'b1; in_valid = 1'b1; in_addr = 4'h9; in_data = 8'h99;
        hold = 1'b0; raddr1 = 4'h0; raddr2 = 4'h0;
        for (int c = 0; c < 2; c++) begin
            #1;
            check("rst_in_ready", c, {7'd0, in_ready}, 8'd0);
            check("rst_mem_wen", c, {7'd0, mem_wen}, 8'd0);
            @(negedge clock);
        end
        reset = 1'b0; in_valid = 1'b0;
        #1;
        check("post_rst_count", 0, {5'd0, count}, 8'd0);
        check("post_rst_empty", 0, {7'd0, empty}, 8'd1);
        check("post_rst_in_ready", 0, {7'd0, in_ready}, 8'd1);
        check("post_rst_mem_wen", 0, {7'd0, mem_wen}, 8'd0);

        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            in_valid = vecs[i].v; in_addr = vecs[i].a; in_data = vecs[i].d;
            hold = vecs[i].h; raddr1 = vecs[i].r1; raddr2 = vecs[i].r2;
            #1;
            $display("row %0d: v=%0d a=%h d=%h hold=%0d rdy=%0d wen=%0d wa=%h wd=%h cnt=%0d rd1=%h rd2=%h",
                     i, in_valid, in_addr, in_data, hold, in_ready, mem_wen, mem_waddr,
                     mem_wdata, count, rdata1, rdata2);
            check("in_ready", i, {7'd0, in_ready}, {7'd0, vecs[i].e_rdy});
            check("mem_wen", i, {7'd0, mem_wen}, {7'd0, vecs[i].e_wen});
            if (vecs[i].e_wen) begin
                check("mem_waddr", i, {4'd0, mem_waddr}, {4'd0, vecs[i].e_waddr});
                check("mem_wdata", i, mem_wdata, vecs[i].e_wdata);
            end
            check("count", i, {5'd0, count}, {5'd0, vecs[i].e_cnt});
            check("empty", i, {7'd0, empty}, {7'd0, (vecs[i].e_cnt == 3'd0)});
`ifdef MEM_WRITE_BUFFER_BYPASS_EN
            check("rdata1", i, rdata1, vecs[i].e_r1f);
            check("rdata2", i, rdata2, vecs[i].e_r2f);
`else
            check("rdata1", i, rdata1, vecs[i].e_r1r);
            check("rdata2", i, rdata2, vecs[i].e_r2r);
`endif
        end

        // Reset pulse with three pending entries (5/0x11, 5/0x22, 8/0x88).
        @(negedge clock);
        reset = 1'b1; in_valid = 1'b0; hold = 1'b0; raddr1 = 4'h5; raddr2 = 4'h8;
        #1;
        check("midrst_mem_wen", 0, {7'd0, mem_wen}, 8'd0);
        check("midrst_in_ready", 0, {7'd0, in_ready}, 8'd0);
        @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            $display("post-reset cycle %0d: wen=%0d cnt=%0d rd1=%h rd2=%h",
                     c, mem_wen, count, rdata1, rdata2);
            check("midrst_after_wen", c, {7'd0, mem_wen}, 8'd0);
            check("midrst_count", c, {5'd0, count}, 8'd0);
            check("midrst_rdata1", c, rdata1, 8'h00);
            check("midrst_rdata2", c, rdata2, 8'h00);
            @(negedge clock);
        end
        check("midrst_empty", 0, {7'd0, empty}, 8'd1);
        check("midrst_in_ready_after", 0, {7'd0, in_ready}, 8'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
